// File: rtl/psram_write_buffer.sv
// rtl/psram_write_buffer.sv - posted-write FIFO in front of a PSRAM with a single outstanding read
// Optional macro PSRAM_WRBUF_FORWARD_EN serves read hits from the FIFO instead of draining first.
module psram_write_buffer #(
  parameter int ADDRESS_BITS = 23,
  parameter int DATA_BITS    = 16,
  parameter int DEPTH        = 4,
  parameter int RD_LATENCY   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDRESS_BITS-1:0] wr_address,
  input  logic [DATA_BITS-1:0]    wr_data,
  output logic                    wr_ready,
  input  logic                    rd_en,
  input  logic [ADDRESS_BITS-1:0] rd_address,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_BITS-1:0]    rd_data,
  output logic                    mem_rd_en,
  output logic [ADDRESS_BITS-1:0] mem_rd_address,
  input  logic                    mem_rd_ack,
  input  logic [DATA_BITS-1:0]    mem_rd_data,
  output logic                    mem_wr_en,
  output logic [ADDRESS_BITS-1:0] mem_wr_address,
  output logic [DATA_BITS-1:0]    mem_wr_data,
  input  logic                    mem_wr_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_PEND = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [ADDRESS_BITS-1:0] fifo_addr [DEPTH];
  logic [DATA_BITS-1:0]    fifo_data [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [PW:0]             count;

  logic [1:0]              state;
  logic [ADDRESS_BITS-1:0] rd_addr_q;
  logic [CW-1:0]           lat_cnt;
  logic                    active;

  logic push;
  logic pop;
  logic rd_accept;
  logic rd_issue;

  assign wr_ready  = active && (count < (PW+1)'(DEPTH));
  assign rd_ready  = active && (state == IDLE) && !rd_valid;
  assign push      = wr_en && wr_ready;
  assign rd_accept = rd_en && rd_ready;

`ifdef PSRAM_WRBUF_FORWARD_EN
  logic                 fwd_hit;
  logic [DATA_BITS-1:0] fwd_data;

  // Scan oldest to newest so the last match wins; the same-cycle write is newest of all.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (fifo_addr[head + PW'(i)] == rd_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[head + PW'(i)];
      end
    end
    if (push && (wr_address == rd_address)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
  end

  assign rd_issue = (state == RD_PEND);
`else
  logic [PW:0] pend_cnt;

  assign rd_issue = (state == RD_PEND) && (pend_cnt == '0);
`endif

  assign mem_wr_en      = (count != '0) && !rd_issue;
  assign pop            = mem_wr_en && mem_wr_ack;
  assign mem_wr_address = mem_wr_en ? fifo_addr[head] : '0;
  assign mem_wr_data    = mem_wr_en ? fifo_data[head] : '0;
  assign mem_rd_en      = rd_issue;
  assign mem_rd_address = rd_issue ? rd_addr_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= wr_address;
      fifo_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      lat_cnt   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      active    <= 1'b0;
`ifndef PSRAM_WRBUF_FORWARD_EN
      pend_cnt  <= '0;
`endif
    end else begin
      active   <= 1'b1;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_addr_q <= rd_address;
`ifdef PSRAM_WRBUF_FORWARD_EN
            if (fwd_hit) begin
              rd_data  <= fwd_data;
              rd_valid <= 1'b1;
            end else begin
              state <= RD_PEND;
            end
`else
            // Every write older than the read, including one posted this cycle, must reach memory first.
            pend_cnt <= count + (PW+1)'(push) - (PW+1)'(pop);
            state    <= RD_PEND;
`endif
          end
        end
        RD_PEND: begin
`ifndef PSRAM_WRBUF_FORWARD_EN
          if (pop && (pend_cnt != '0)) pend_cnt <= pend_cnt - (PW+1)'(1);
`endif
          if (rd_issue && mem_rd_ack) begin
            state   <= RD_WAIT;
            lat_cnt <= CW'(1);
          end
        end
        RD_WAIT: begin
          if (lat_cnt == CW'(RD_LATENCY)) begin
            rd_data  <= mem_rd_data;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psram_write_buffer.md
PSRAM_WRITE_BUFFER -- requirements
Module: psram_write_buffer

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 23, meaning the word address width including the bank bit.
REQ-002 SHALL have parameter DATA_BITS, default 16, meaning the data word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of posted-write FIFO entries (a power of 2, at least 2).
REQ-004 SHALL have parameter RD_LATENCY, default 3, meaning the cycles from mem_rd_ack until mem_rd_data is valid (at least 1).
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports clk (in, 1) and reset (in, 1), listed first.
REQ-006 SHALL have client write ports: wr_en (in, 1), wr_address (in, ADDRESS_BITS), wr_data (in, DATA_BITS), wr_ready (out, 1); a write is accepted when wr_en && wr_ready.
REQ-007 SHALL have client read ports: rd_en (in, 1), rd_address (in, ADDRESS_BITS), rd_ready (out, 1), rd_valid (out, 1, one-cycle pulse), rd_data (out, DATA_BITS); a read is accepted when rd_en && rd_ready.
REQ-008 SHALL have memory-side ports: mem_rd_en (out, 1), mem_rd_address (out, ADDRESS_BITS), mem_rd_ack (in, 1), mem_rd_data (in, DATA_BITS), mem_wr_en (out, 1), mem_wr_address (out, ADDRESS_BITS), mem_wr_data (out, DATA_BITS), mem_wr_ack (in, 1).

Function
REQ-009 SHALL post accepted writes into the FIFO in order; wr_ready = (count < DEPTH), with no same-cycle pass-through when full.
REQ-010 SHALL drive mem_wr_en/address/data from the FIFO head while non-empty and no read is being issued; mem_wr_ack pops the head in the same cycle.
REQ-011 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-012 SHALL allow at most one read in flight; rd_ready = 0 from acceptance through the rd_valid cycle inclusive.
REQ-013 SHALL use states IDLE -> RD_PEND (accepted, not issued) -> RD_WAIT (acked, counting) -> IDLE; the rd_valid cycle returns to IDLE.
REQ-014 SHALL, in RD_PEND with no older write blocking, assert mem_rd_en with the latched address; a read has priority over the FIFO drain.
REQ-015 SHALL, RD_LATENCY cycles after mem_rd_ack, register mem_rd_data to rd_data and pulse rd_valid one cycle later.
REQ-016 SHALL hold rd_data stable between rd_valid pulses.
REQ-017 SHALL let writes accepted after a read was accepted never affect that read's data.
REQ-018 SHALL, on a same-cycle write and read to the same address, order the write first; the read returns the new data.
REQ-019 SHALL keep FIFO pointers at clog2(DEPTH) bits, wrapping naturally, with a separate count of clog2(DEPTH)+1 bits; a simultaneous push and pop leaves the count unchanged.

Reset
REQ-020 SHALL, on reset asserted at any time (including mid-read or mid-drain): empty the FIFO, enter IDLE, drop any in-flight read with no rd_valid, and drive rd_data=0, rd_valid=0, mem_rd_en=0, mem_wr_en=0, mem_*_address=0, mem_wr_data=0.
REQ-021 SHALL, while reset is asserted, hold wr_ready=0 and rd_ready=0; both go to 1 the first cycle after release.

Configuration
REQ-022 SHALL use macro PSRAM_WRBUF_FORWARD_EN to select the read-hit behaviour.
REQ-023 SHALL, with PSRAM_WRBUF_FORWARD_EN defined, compare an accepted read against all valid FIFO entries plus the same-cycle accepted write. On a hit: no memory read is issued, rd_data is the newest matching data, and rd_valid is pulsed the next cycle.
REQ-024 SHALL, without PSRAM_WRBUF_FORWARD_EN, do no comparison. On acceptance it snapshots the FIFO count, including any same-cycle write. Drain takes priority until that many pops have occurred, and only then is mem_rd_en issued.

Verification
REQ-025 SHALL test: write 0x000010=0xBEEF with mem_wr_ack tied high -> mem_wr_en the cycle after acceptance, address 0x000010, data 0xBEEF, FIFO empty after.
REQ-026 SHALL test: mem_wr_ack held low, 5 back-to-back writes with DEPTH=4 -> wr_ready=0 after the 4th, the 5th is accepted only after the first ack, and all 5 reach memory in order.
REQ-027 SHALL test: read 0x000040 on an empty FIFO, mem_rd_ack on the issue cycle, mem_rd_data=0x1234 at +3 -> rd_valid at ack+4 with rd_data=0x1234.
REQ-028 SHALL test (forward on): writes 0x20=0x1111 then 0x20=0x2222 stalled, then read 0x20 -> rd_valid the next cycle with 0x2222, and mem_rd_en never asserted.
REQ-029 SHALL test (forward off): the same stimulus -> both writes drained before mem_rd_en asserts for 0x20.
REQ-030 SHALL test: reset asserted during RD_WAIT -> no rd_valid, all outputs 0 immediately, ready the cycle after release.
